snake_dir_ctrl: RTL and testbench
=================================

// Module: snake_dir_ctrl
// PURPOSE
//  Conditions the raw right_P/left_P pushbuttons: synchronises, debounces and edge-detects them.
//  Turns each accepted press into a relative turn that is applied to the snake heading on the next game_tik.
//  Sits directly upstream of the snake movement/FSM logic. Drives up/down/left/right and the start pulse for that logic.
//  Allows at most one 90-degree turn per game_tik, so a 180-degree reversal into the body is impossible.
// PARAMETERS
//  DEBOUNCE_BITS  18     debounce counter width; a level must be stable for 2**DEBOUNCE_BITS cycles (~10.5 ms @25 MHz)
//  INIT_DIR       2'd0   heading after reset: 0=RIGHT 1=DOWN 2=LEFT 3=UP
// PORTS
//  clock_25        in   1  25 MHz system clock; all state changes on its rising edge
//  reset           in   1  synchronous, active-high reset
//  right_P         in   1  raw right pushbutton, asynchronous, 1 = pressed
//  left_P          in   1  raw left pushbutton, asynchronous, 1 = pressed
//  game_tik        in   1  one-cycle pulse per snake step
//  enable          in   1  1 while the game is in its play state
//  right_sync      out  1  debounced right button level
//  left_sync       out  1  debounced left button level
//  right_register  out  1  clockwise turn pending
//  left_register   out  1  counter-clockwise turn pending
//  right,down,left,up out 1 each  one-hot current heading
//  start           out  1  one-cycle pulse on any accepted press; independent of enable
// BEHAVIOUR
//  Reset, synchronous on clock_25 while reset=1:
//   - all synchroniser flops, debounce counters, right_sync and left_sync go to 0
//   - pending registers and start go to 0
//   - heading = INIT_DIR; with default, right=1 and up/down/left=0
//   - reset asserted mid-debounce or mid-turn discards all progress
//  Sync: 2-flop synchroniser per button. Raw input is never used elsewhere.
//  Debounce, per button; cnt is DEBOUNCE_BITS wide, MAX = 2**DEBOUNCE_BITS-1:
//   - sync == stable: cnt <= 0
//   - sync != stable and cnt < MAX: cnt <= cnt+1
//   - sync != stable and cnt == MAX: stable <= sync, cnt <= 0
//   - stable drives right_sync/left_sync
//   - any bounce back to the stable level restarts the count
//  Latency: raw step to *_sync change = 2 + 2**DEBOUNCE_BITS edges.
//  Press pulse: press = stable & ~stable_q (stable_q is the one-cycle-delayed stable). Release is never a press.
//  start: registered; high exactly one cycle, one edge after any press pulse.
//  Heading FSM, 2-bit state RIGHT(0) -> DOWN(1) -> LEFT(2) -> UP(3) -> RIGHT:
//   - clockwise step = +1 mod 4; counter-clockwise step = -1 mod 4; wrap is natural 2-bit arithmetic
//   - outputs are a one-hot decode of the state register; exactly one is high at all times
//  Pending turn, updated on the edge after the press pulse:
//   - right press, enable=1: right_register <= 1, left_register <= 0 (latest press wins)
//   - left press, enable=1: symmetric
//   - both press pulses in the same cycle: both ignored, pending unchanged
//   - game_tik=1 and a turn pending: state steps once, both pending registers clear
//   - game_tik=1 and no turn pending: state holds
//   - game_tik and a press in the same cycle: the old pending turn is applied first; the new press becomes pending for the next tik
//   - enable=0: pending registers forced to 0, state holds, presses ignored for turning; start still pulses
//   - multiple presses between tiks: only the last is kept, so one turn per tik
// TESTING  (bench uses DEBOUNCE_BITS=4, so MAX=15 and debounce latency = 18 edges)
//  1. Reset held 3 cycles -> right=1; up/down/left=0; right_sync=left_sync=right_register=left_register=start=0.
//  2. enable=1, right_P held high from edge 0 -> right_sync=1 at edge 18; start=1 for one cycle at edge 19 only;
//     right_register=1 at edge 19; next game_tik -> down=1 and right_register=0.
//  3. right_P glitch high for 10 cycles, then low -> right_sync stays 0; no start pulse; heading unchanged.
//  4. Heading UP, one left press then one tik -> LEFT; from UP, four right presses each followed by a tik ->
//     RIGHT, DOWN, LEFT, UP (wrap 3 -> 0 checked).
//  5. right then left press before a tik -> left_register=1, right_register=0; tik turns counter-clockwise once only;
//     a press coincident with a tik is applied on the following tik.
//  6. enable=0 with a right press -> start pulses, right_register stays 0, heading frozen;
//     reset during a debounce count -> count restarts and no press is produced.

Source files
------------

// File: rtl/snake_dir_ctrl.sv
// Pushbutton conditioning and heading control for the snake game.
// Buttons are synchronised, debounced and edge-detected, then turned into at most one 90-degree turn per game_tik.
module snake_dir_ctrl #(
    parameter int         DEBOUNCE_BITS = 18,
    parameter logic [1:0] INIT_DIR      = 2'd0
) (
    input  logic clock_25,
    input  logic reset,
    input  logic right_P,
    input  logic left_P,
    input  logic game_tik,
    input  logic enable,
    output logic right_sync,
    output logic left_sync,
    output logic right_register,
    output logic left_register,
    output logic right,
    output logic down,
    output logic left,
    output logic up,
    output logic start
);

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_e;

    localparam logic [DEBOUNCE_BITS-1:0] CNT_ZERO = {DEBOUNCE_BITS{1'b0}};
    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX  = {DEBOUNCE_BITS{1'b1}};
    localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE  = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

    // Bit 0 of the result drives right, 1 down, 2 left, 3 up.
    function automatic logic [3:0] dir_onehot(input dir_e d);
        logic [3:0] oh;
        case (d)
            DIR_RIGHT: oh = 4'b0001;
            DIR_DOWN:  oh = 4'b0010;
            DIR_LEFT:  oh = 4'b0100;
            DIR_UP:    oh = 4'b1000;
            default:   oh = 4'b0001;
        endcase
        return oh;
    endfunction

    // Index 0 carries the right button, index 1 the left button throughout.
    logic [1:0]               btn_raw_s;
    logic [1:0]               meta_q;
    logic [1:0]               sync_q;
    logic [1:0]               stable_q;
    logic [1:0]               stable_d;
    logic [1:0]               stable_dly_q;
    logic [1:0]               press_s;
    logic [DEBOUNCE_BITS-1:0] cnt_q [2];
    logic [DEBOUNCE_BITS-1:0] cnt_d [2];

    logic cw_press_s;
    logic ccw_press_s;
    logic pend_cw_q;
    logic pend_cw_d;
    logic pend_ccw_q;
    logic pend_ccw_d;
    logic start_q;
    dir_e state_q;
    dir_e state_d;
    logic [3:0] head_q;

    assign btn_raw_s   = {left_P, right_P};
    assign press_s     = stable_q & ~stable_dly_q;
    // Simultaneous presses cancel each other so neither can sneak a turn through.
    assign cw_press_s  = press_s[0] & ~press_s[1];
    assign ccw_press_s = press_s[1] & ~press_s[0];

    // Debounce next-state: a level must differ for 2**DEBOUNCE_BITS consecutive cycles to be accepted.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]    = cnt_q[i];
            stable_d[i] = stable_q[i];
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = CNT_ZERO;
            end
        end
    end

    // Synchroniser, debounce counters and press edge detector.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            meta_q       <= 2'b00;
            sync_q       <= 2'b00;
            stable_q     <= 2'b00;
            stable_dly_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            meta_q       <= btn_raw_s;
            sync_q       <= meta_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Pending turn: a tik consumes the old turn before a coincident press is recorded.
    always_comb begin
        pend_cw_d  = pend_cw_q;
        pend_ccw_d = pend_ccw_q;
        if (!enable) begin
            pend_cw_d  = 1'b0;
            pend_ccw_d = 1'b0;
        end else begin
            if (game_tik) begin
                pend_cw_d  = 1'b0;
                pend_ccw_d = 1'b0;
            end else begin
                pend_cw_d  = pend_cw_q;
                pend_ccw_d = pend_ccw_q;
            end
            if (cw_press_s) begin
                pend_cw_d  = 1'b1;
                pend_ccw_d = 1'b0;
            end else if (ccw_press_s) begin
                pend_cw_d  = 1'b0;
                pend_ccw_d = 1'b1;
            end else begin
                pend_cw_d  = pend_cw_d;
                pend_ccw_d = pend_ccw_d;
            end
        end
    end

    // Heading next-state: 2-bit wrap gives UP -> RIGHT and RIGHT -> UP for free.
    always_comb begin
        state_d = state_q;
        if (!enable || !game_tik) begin
            state_d = state_q;
        end else if (pend_cw_q) begin
            state_d = dir_e'(state_q + 2'd1);
        end else if (pend_ccw_q) begin
            state_d = dir_e'(state_q - 2'd1);
        end else begin
            state_d = state_q;
        end
    end

    // Heading FSM with registered one-hot decode, pending turns and start pulse.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_q    <= dir_e'(INIT_DIR);
            head_q     <= dir_onehot(dir_e'(INIT_DIR));
            pend_cw_q  <= 1'b0;
            pend_ccw_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= dir_onehot(state_d);
            pend_cw_q  <= pend_cw_d;
            pend_ccw_q <= pend_ccw_d;
            start_q    <= |press_s;
        end
    end

    assign right_sync     = stable_q[0];
    assign left_sync      = stable_q[1];
    assign right_register = pend_cw_q;
    assign left_register  = pend_ccw_q;
    assign right          = head_q[0];
    assign down           = head_q[1];
    assign left           = head_q[2];
    assign up             = head_q[3];
    assign start          = start_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl: directed scenarios plus random button activity,
// all checked every cycle against a behavioural model of buttons, turns and heading.
module tb_snake_dir_ctrl;

    localparam int DB      = 4;
    localparam int RUN_MAX = 1 << DB;

    logic clock_25 = 1'b0;
    logic reset    = 1'b1;
    logic right_P  = 1'b0;
    logic left_P   = 1'b0;
    logic game_tik = 1'b0;
    logic enable   = 1'b0;
    logic right_sync, left_sync, right_register, left_register;
    logic right, down, left, up, start;

    int total  = 0;
    int bad    = 0;
    int starts = 0;

    // Model: per-button pipeline and run length, heading 0..3, turn as +1/-1/0.
    bit m_meta [2];
    bit m_sync [2];
    bit m_stab [2];
    bit m_dly  [2];
    int m_run  [2];
    bit m_start = 1'b0;
    int m_head  = 0;
    int m_turn  = 0;

    logic [3:0] exp_seq [4];

    snake_dir_ctrl #(.DEBOUNCE_BITS(DB), .INIT_DIR(2'd0)) dut (
        .clock_25(clock_25), .reset(reset), .right_P(right_P), .left_P(left_P),
        .game_tik(game_tik), .enable(enable), .right_sync(right_sync), .left_sync(left_sync),
        .right_register(right_register), .left_register(left_register),
        .right(right), .down(down), .left(left), .up(up), .start(start)
    );

    always #20 clock_25 = ~clock_25;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] head_oh();
        return {up, left, down, right};
    endfunction

    task automatic tick();
        bit raw [2];
        bit pr  [2];
        bit en, tk, rs;
        logic [3:0] exp_oh;
        raw[0] = right_P;
        raw[1] = left_P;
        en = enable;
        tk = game_tik;
        rs = reset;
        @(posedge clock_25);
        if (rs) begin
            for (int i = 0; i < 2; i++) begin
                m_meta[i] = 1'b0; m_sync[i] = 1'b0; m_stab[i] = 1'b0; m_dly[i] = 1'b0; m_run[i] = 0;
            end
            m_start = 1'b0;
            m_head  = 0;
            m_turn  = 0;
        end else begin
            for (int i = 0; i < 2; i++) pr[i] = m_stab[i] && !m_dly[i];
            m_start = pr[0] || pr[1];
            if (!en) begin
                m_turn = 0;
            end else begin
                if (tk && m_turn != 0) begin
                    m_head = (m_head + m_turn + 4) % 4;
                    m_turn = 0;
                end
                if (pr[0] && !pr[1]) m_turn = 1;
                else if (pr[1] && !pr[0]) m_turn = -1;
            end
            for (int i = 0; i < 2; i++) begin
                m_dly[i] = m_stab[i];
                if (m_sync[i] != m_stab[i]) begin
                    m_run[i]++;
                    if (m_run[i] == RUN_MAX) begin
                        m_stab[i] = m_sync[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_sync[i] = m_meta[i];
                m_meta[i] = raw[i];
            end
        end
        #1;
        exp_oh = 4'b0001 << m_head;
        chk("right_sync", 32'(right_sync), 32'(m_stab[0]));
        chk("left_sync", 32'(left_sync), 32'(m_stab[1]));
        chk("start", 32'(start), 32'(m_start));
        chk("right_register", 32'(right_register), 32'(m_turn == 1));
        chk("left_register", 32'(left_register), 32'(m_turn == -1));
        chk("heading", 32'(head_oh()), 32'(exp_oh));
        if (start === 1'b1) starts++;
    endtask

    task automatic press(input int btn);
        if (btn == 0) right_P = 1'b1; else left_P = 1'b1;
        repeat (20) tick();
        right_P = 1'b0;
        left_P  = 1'b0;
        repeat (20) tick();
    endtask

    task automatic tik();
        game_tik = 1'b1;
        tick();
        game_tik = 1'b0;
        tick();
    endtask

    initial begin
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000;

        // Reset held for three cycles.
        repeat (3) tick();
        chk("rst_heading", 32'(head_oh()), 32'(4'b0001));
        chk("rst_start", 32'(start), 32'(1'b0));
        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) tick();

        // Clean right press: sync at edge 18, start and pending at edge 19.
        right_P = 1'b1;
        repeat (17) tick();
        chk("lat_sync_17", 32'(right_sync), 32'(1'b0));
        tick();
        chk("lat_sync_18", 32'(right_sync), 32'(1'b1));
        chk("lat_start_18", 32'(start), 32'(1'b0));
        tick();
        chk("lat_start_19", 32'(start), 32'(1'b1));
        chk("lat_rreg_19", 32'(right_register), 32'(1'b1));
        tick();
        chk("lat_start_20", 32'(start), 32'(1'b0));
        game_tik = 1'b1;
        tick();
        game_tik = 1'b0;
        chk("first_turn_down", 32'(head_oh()), 32'(4'b0010));
        chk("first_turn_rreg", 32'(right_register), 32'(1'b0));
        right_P = 1'b0;
        repeat (20) tick();

        // Short glitch is filtered.
        starts  = 0;
        right_P = 1'b1;
        repeat (10) tick();
        right_P = 1'b0;
        repeat (20) tick();
        chk("glitch_starts", 32'(starts), 32'(0));
        chk("glitch_heading", 32'(head_oh()), 32'(4'b0010));

        // DOWN -> RIGHT -> UP, then UP -> LEFT -> UP, then four clockwise steps with wrap.
        press(1); tik();
        press(1); tik();
        chk("reach_up", 32'(head_oh()), 32'(4'b1000));
        press(1); tik();
        chk("up_ccw_left", 32'(head_oh()), 32'(4'b0100));
        press(0); tik();
        for (int k = 0; k < 4; k++) begin
            press(0); tik();
            chk($sformatf("cw_step%0d", k), 32'(head_oh()), 32'(exp_seq[k]));
        end

        // Latest press wins; one turn per tik.
        press(0);
        press(1);
        chk("latest_lreg", 32'(left_register), 32'(1'b1));
        chk("latest_rreg", 32'(right_register), 32'(1'b0));
        tik();
        chk("latest_turn", 32'(head_oh()), 32'(4'b0100));
        tik();
        chk("single_turn", 32'(head_oh()), 32'(4'b0100));

        // Press coincident with a tik becomes pending for the next tik.
        press(0);
        left_P = 1'b1;
        repeat (18) tick();
        game_tik = 1'b1;
        tick();
        game_tik = 1'b0;
        chk("coinc_old_applied", 32'(head_oh()), 32'(4'b1000));
        chk("coinc_new_pending", 32'(left_register), 32'(1'b1));
        left_P = 1'b0;
        repeat (20) tick();
        tik();
        chk("coinc_next_tik", 32'(head_oh()), 32'(4'b0100));

        // Disabled: start still pulses, no turn, heading frozen.
        enable = 1'b0;
        starts = 0;
        press(0);
        chk("dis_starts", 32'(starts), 32'(1));
        chk("dis_rreg", 32'(right_register), 32'(1'b0));
        tik();
        chk("dis_heading", 32'(head_oh()), 32'(4'b0100));
        enable = 1'b1;

        // Reset mid-debounce discards the count.
        right_P = 1'b1;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        starts = 0;
        chk("mid_rst_heading", 32'(head_oh()), 32'(4'b0001));
        repeat (17) tick();
        chk("mid_rst_sync_17", 32'(right_sync), 32'(1'b0));
        chk("mid_rst_starts", 32'(starts), 32'(0));
        tick();
        chk("mid_rst_sync_18", 32'(right_sync), 32'(1'b1));
        right_P = 1'b0;
        repeat (20) tick();

        // Random bouncy buttons, tiks, enable and occasional reset.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 29) == 0) right_P = ~right_P;
            if ($urandom_range(0, 29) == 0) left_P = ~left_P;
            game_tik = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset    = 1'b0;
        game_tik = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
